instr_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the 19-bit CPU core. Generates sequential fetch addresses into instruction memory over a request/grant/response interface, buffers returned words with their PCs in a small prefetch queue, and presents them to the core over a valid/ready handshake. Control-flow redirects (JMP, taken BEQ/BNE, CALL, RET) restart fetch at a new address and discard all stale words, both queued and in flight.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_queue.sv | 54 +++++
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 19-bit core and its fetch stage.
package cpu_pkg;

  localparam int DATA_W   = 19;
  localparam int ADDR_W   = 14;
  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_JMP  = 5'h10;
  localparam logic [OPCODE_W-1:0] OP_BEQ  = 5'h11;
  localparam logic [OPCODE_W-1:0] OP_BNE  = 5'h12;
  localparam logic [OPCODE_W-1:0] OP_CALL = 5'h13;
  localparam logic [OPCODE_W-1:0] OP_RET  = 5'h14;

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Small first-word-fall-through FIFO holding {pc, word} pairs for the fetch stage.
module fetch_queue #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  // Head is forced to zero when empty so the outputs have defined reset values.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: credit-limited sequential fetch, prefetch queue, redirect with stale-response drain.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int CW = $clog2(DEPTH+1);

  fetch_state_t        state;
  logic [ADDR_W-1:0]   fetch_pc;
  logic [ADDR_W-1:0]   resp_pc;
  logic [CW-1:0]       outstanding;
  logic [CW-1:0]       discard;
  logic [CW-1:0]       occupancy;
  logic [CW:0]         credit_used;
  logic [CW-1:0]       stale_total;
  logic [CW-1:0]       stale_next;
  logic                grant;
  logic                push;
  logic                pop;
  logic [ADDR_W+DATA_W-1:0] head;

  assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
  assign imem_req    = !reset && (state == FETCH) && !redirect && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;
  assign grant       = imem_req && imem_gnt;
  assign push        = imem_rvalid && (state == FETCH) && !redirect;
  assign pop         = instr_valid && instr_ready;

  // Only one of outstanding/discard is nonzero at any time, so the sum is the stale count.
  always_comb begin
    stale_total = outstanding + discard;
    stale_next  = stale_total;
    if (imem_rvalid && stale_total != '0) stale_next = stale_total - CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      fetch_pc    <= '0;
      resp_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      outstanding <= '0;
      discard     <= stale_next;
      state       <= (stale_next != '0) ? DRAIN : FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (grant) fetch_pc <= fetch_pc + ADDR_W'(1);
          if (push)  resp_pc  <= resp_pc + ADDR_W'(1);
          case ({grant, push})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
          endcase
        end
        DRAIN: begin
          if (imem_rvalid) begin
            discard <= discard - CW'(1);
            if (discard == CW'(1)) state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  fetch_queue #(
    .WIDTH(ADDR_W + DATA_W),
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({resp_pc, imem_rdata}),
    .pop       (pop),
    .flush     (redirect),
    .count     (occupancy),
    .head_valid(instr_valid),
    .head_data (head)
  );

  assign instr_pc    = head[ADDR_W+DATA_W-1:DATA_W];
  assign instruction = head[DATA_W-1:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: in-order memory model plus a queue-level reference of the fetch stream.
module tb_instr_fetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instruction(instruction), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  typedef struct { logic [ADDR_W-1:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [ADDR_W-1:0] pc; logic [DATA_W-1:0] data; } ent_t;

  req_t pend[$];
  req_t cur;
  bit   cur_v;
  ent_t mq[$];
  logic [ADDR_W-1:0] m_pc;
  int   cyc, last_due, lat_min, lat_max, gnt_pct;
  bit   exp_req, exp_valid;
  ent_t exp_head;
  bit   s_rd, s_rdy;
  logic [ADDR_W-1:0] s_rpc;
  int   errors = 0;
  int   checks = 0;

  function automatic logic [DATA_W-1:0] word_at(input logic [ADDR_W-1:0] a);
    return {a[4:0] ^ 5'h15, a ^ 14'h1A5B};
  endfunction

  // Drive one cycle's inputs just after a rising edge, then predict the outputs.
  task automatic drive(input bit rd, input logic [ADDR_W-1:0] rpc, input bit rdy);
    int live, stale;
    redirect = rd; redirect_pc = rpc; instr_ready = rdy;
    s_rd = rd; s_rdy = rdy; s_rpc = rpc;
    cur_v = 0; imem_rvalid = 0; imem_rdata = '0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      cur = pend.pop_front(); cur_v = 1;
      imem_rvalid = 1; imem_rdata = word_at(cur.addr);
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    live = 0; stale = 0;
    foreach (pend[i]) if (pend[i].stale) stale++; else live++;
    if (cur_v) begin if (cur.stale) stale++; else live++; end
    exp_req   = !rd && stale == 0 && (live + mq.size() < DEPTH);
    exp_valid = mq.size() != 0;
    if (exp_valid) exp_head = mq[0];
    @(negedge clk);
  endtask

  // Apply the cycle's events to the reference and move to the next cycle.
  task automatic advance();
    bit grant, pop;
    req_t r;
    ent_t e;
    int due;
    grant = imem_req && imem_gnt;
    pop   = exp_valid && s_rdy;
    if (pop) void'(mq.pop_front());
    if (s_rd) begin
      foreach (pend[i]) pend[i].stale = 1;
      mq.delete();
      m_pc = s_rpc;
    end else if (cur_v && !cur.stale) begin
      e.pc = cur.addr; e.data = word_at(cur.addr);
      mq.push_back(e);
    end
    if (grant) begin
      due = cyc + $urandom_range(lat_max, lat_min);
      if (due <= last_due) due = last_due + 1;
      r.addr = imem_addr; r.due = due; r.stale = s_rd;
      pend.push_back(r); last_due = due;
      if (!s_rd) m_pc = m_pc + ADDR_W'(1);
    end
    assert (dut.occupancy <= DEPTH) else $error("FAIL overflow occupancy=%0d limit=%0d", dut.occupancy, DEPTH);
    @(posedge clk); cyc++; #1;
  endtask

  task automatic clear_model();
    pend.delete(); mq.delete(); cur_v = 0; m_pc = '0; last_due = 0;
  endtask

  task automatic apply_reset();
    reset = 1; redirect = 0; redirect_pc = '0; imem_gnt = 0; imem_rvalid = 0;
    imem_rdata = '0; instr_ready = 0;
    clear_model();
    @(posedge clk); cyc++; #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", imem_req); end
    checks++; if (imem_addr !== '0) begin errors++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", instr_valid); end
    checks++; if (instruction !== '0) begin errors++; $display("FAIL rst_instr got=%h exp=0", instruction); end
    checks++; if (instr_pc !== '0) begin errors++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
    reset = 0;
  endtask

  task automatic test_sequential();
    apply_reset(); reset = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    for (int i = 0; i < 24; i++) begin
      drive(0, '0, 1);
      checks++; if (imem_req !== 1'b1 || imem_addr !== ADDR_W'(i)) begin errors++;
        $display("FAIL seq_addr i=%0d got req=%0b addr=%0d exp req=1 addr=%0d", i, imem_req, imem_addr, i); end
      if (i >= 2) begin
        checks++; if (instr_valid !== 1'b1 || instr_pc !== ADDR_W'(i-2) || instruction !== word_at(ADDR_W'(i-2))) begin errors++;
          $display("FAIL seq_deliver i=%0d got v=%0b pc=%0d w=%h exp v=1 pc=%0d", i, instr_valid, instr_pc, instruction, i-2); end
      end
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL seq_req cyc=%0d got=%0b exp=%0b", cyc, imem_req, exp_req); end
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL seq_valid cyc=%0d got=%0b exp=%0b", cyc, instr_valid, exp_valid); end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int grants, k;
    logic [ADDR_W-1:0] first_addr;
    bit got_first;
    apply_reset(); reset = 0;
    lat_min = 1; lat_max = 1; gnt_pct = 100; grants = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, '0, 0);
      if (imem_req && imem_gnt) grants++;
      advance();
    end
    drive(0, '0, 0);
    checks++; if (grants != DEPTH) begin errors++; $display("FAIL bp_grants got=%0d exp=%0d", grants, DEPTH); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_hold got=%0b exp=0", imem_req); end
    checks++; if (instr_valid !== 1'b1 || instr_pc !== '0) begin errors++; $display("FAIL bp_head got v=%0b pc=%0d exp v=1 pc=0", instr_valid, instr_pc); end
    advance();
    k = 0; got_first = 0; first_addr = '0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 1);
      if (imem_req && imem_gnt && !got_first) begin got_first = 1; first_addr = imem_addr; end
      if (instr_valid && k < 6) begin
        checks++; if (instr_pc !== ADDR_W'(k)) begin errors++; $display("FAIL bp_order k=%0d got=%0d exp=%0d", k, instr_pc, k); end
        k++;
      end
      advance();
    end
    checks++; if (!got_first || first_addr !== ADDR_W'(4)) begin errors++; $display("FAIL bp_resume got=%0d seen=%0b exp=4", first_addr, got_first); end
  endtask

  task automatic test_redirect_drain();
    int zeros;
    bit found;
    apply_reset(); reset = 0;
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    for (int i = 0; i < 3; i++) begin drive(0, '0, 1); advance(); end
    drive(1, 14'h0100, 1);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_forced got=%0b exp=0", imem_req); end
    advance();
    zeros = 1; found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      drive(0, '0, 1);
      if (imem_req) begin
        found = 1;
        checks++; if (imem_addr !== 14'h0100) begin errors++; $display("FAIL rd_addr got=%h exp=0100", imem_addr); end
      end else begin
        zeros++;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rd_stale_word got v=%0b pc=%h exp v=0", instr_valid, instr_pc); end
      end
      advance();
    end
    checks++; if (!found || zeros != 3) begin errors++; $display("FAIL rd_drain_len got=%0d found=%0b exp=3", zeros, found); end
    found = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, '0, 1);
      if (instr_valid && !found) begin
        found = 1;
        checks++; if (instr_pc !== 14'h0100) begin errors++; $display("FAIL rd_first_pc got=%h exp=0100", instr_pc); end
      end
      advance();
    end
    checks++; if (!found) begin errors++; $display("FAIL rd_timeout got=none exp=instruction"); end
  endtask

  task automatic test_wrap();
    bit addr_wrap, pc_wrap;
    logic [ADDR_W-1:0] prev_a, prev_p;
    lat_min = 1; lat_max = 1; gnt_pct = 100;
    drive(1, 14'h3FFE, 1); advance();
    addr_wrap = 0; pc_wrap = 0; prev_a = '0; prev_p = '0;
    for (int i = 0; i < 16; i++) begin
      drive(0, '0, 1);
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL wrap_req cyc=%0d got=%0b exp=%0b", cyc, imem_req, exp_req); end
      if (exp_req) begin checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc); end end
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL wrap_valid cyc=%0d got=%0b exp=%0b", cyc, instr_valid, exp_valid); end
      if (exp_valid) begin checks++; if (instr_pc !== exp_head.pc || instruction !== exp_head.data) begin errors++;
        $display("FAIL wrap_head cyc=%0d got pc=%h w=%h exp pc=%h w=%h", cyc, instr_pc, instruction, exp_head.pc, exp_head.data); end end
      if (imem_req && imem_gnt) begin if (prev_a == 14'h3FFF && imem_addr == '0) addr_wrap = 1; prev_a = imem_addr; end
      if (instr_valid && instr_ready) begin if (prev_p == 14'h3FFF && instr_pc == '0) pc_wrap = 1; prev_p = instr_pc; end
      advance();
    end
    checks++; if (!addr_wrap) begin errors++; $display("FAIL wrap_addr_seq got=no_wrap exp=3fff_then_0"); end
    checks++; if (!pc_wrap) begin errors++; $display("FAIL wrap_pc_seq got=no_wrap exp=3fff_then_0"); end
  endtask

  task automatic test_redirect_pop();
    lat_min = 2; lat_max = 2; gnt_pct = 100;
    for (int i = 0; i < 10; i++) begin drive(0, '0, 1); advance(); end
    drive(1, 14'h2000, 1);
    checks++; if (imem_rvalid !== 1'b1 || instr_valid !== 1'b1) begin errors++;
      $display("FAIL rp_setup got rvalid=%0b valid=%0b exp both 1", imem_rvalid, instr_valid); end
    advance();
    drive(0, '0, 1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rp_flush got=%0b exp=0", instr_valid); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rp_drain1 got=%0b exp=0", imem_req); end
    advance();
    drive(0, '0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== 14'h2000) begin errors++;
      $display("FAIL rp_restart got req=%0b addr=%h exp req=1 addr=2000", imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_reset_mid_drain();
    lat_min = 3; lat_max = 3; gnt_pct = 100;
    for (int i = 0; i < 5; i++) begin drive(0, '0, 1); advance(); end
    drive(1, 14'h0555, 1); advance();
    drive(0, '0, 1);
    checks++; if (imem_req !== 1'b0 || imem_req !== exp_req) begin errors++; $display("FAIL rmd_in_drain got=%0b exp=0", imem_req); end
    advance();
    reset = 1; clear_model(); imem_rvalid = 0; redirect = 0;
    @(posedge clk); cyc++; #1;
    checks++; if ({imem_req, imem_addr, instr_valid, instruction, instr_pc} !== '0) begin errors++;
      $display("FAIL rmd_outputs got req=%0b addr=%h v=%0b w=%h pc=%h exp all 0", imem_req, imem_addr, instr_valid, instruction, instr_pc); end
    reset = 0;
    drive(0, '0, 1);
    checks++; if (imem_req !== 1'b1 || imem_addr !== '0) begin errors++; $display("FAIL rmd_restart got req=%0b addr=%h exp req=1 addr=0", imem_req, imem_addr); end
    advance();
  endtask

  task automatic test_random();
    bit rd;
    logic [ADDR_W-1:0] rpc;
    lat_min = 1; lat_max = 4; gnt_pct = 70;
    for (int i = 0; i < 600; i++) begin
      rd  = ($urandom_range(99) < 4);
      rpc = ($urandom_range(3) == 0) ? ADDR_W'(16380 + $urandom_range(3)) : ADDR_W'($urandom);
      drive(rd, rpc, $urandom_range(99) < 75);
      checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rnd_req cyc=%0d got=%0b exp=%0b", cyc, imem_req, exp_req); end
      if (exp_req) begin checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_pc); end end
      checks++; if (instr_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, instr_valid, exp_valid); end
      if (exp_valid) begin checks++; if (instr_pc !== exp_head.pc || instruction !== exp_head.data) begin errors++;
        $display("FAIL rnd_head cyc=%0d got pc=%h w=%h exp pc=%h w=%h", cyc, instr_pc, instruction, exp_head.pc, exp_head.data); end end
      advance();
    end
  endtask

  initial begin
    cyc = 0; lat_min = 1; lat_max = 1; gnt_pct = 100;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_drain();
    test_wrap();
    test_redirect_pop();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
